// File: rtl/chaos_bit_permuter.sv
// chaos_bit_permuter
//   Shuffles the bits of a WIDTH-bit chaos word through a programmable
//   permutation table. The output is registered, so latency is one cycle, and
//   it uses a valid/ready handshake on both sides. Each output bit i takes
//   input bit active[i]. Duplicate table entries are allowed and replicate
//   bits. The table is reprogrammed through a shadow copy. A commit is only
//   accepted after every shadow entry has been written since the last
//   accepted commit.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   in_valid/ready   input beat handshake (in_ready = !out_valid || out_ready)
//   in_data          word to shuffle
//   perm_en          sampled with the beat: 1 = permute, 0 = bypass
//   out_valid/ready  output beat handshake
//   out_data         registered shuffled word
//   cfg_we           write shadow[cfg_addr] = cfg_data
//   cfg_addr         output bit index being programmed
//   cfg_data         source input bit index for that output bit
//   cfg_commit       request shadow -> active copy
//   cfg_ack          one-cycle pulse: commit accepted
//   cfg_err          one-cycle pulse: commit rejected (table incompletely written)
module chaos_bit_permuter #(
   parameter int WIDTH = 256,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             perm_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_addr,
   input  logic [IDX_W-1:0] cfg_data,
   input  logic             cfg_commit,
   output logic             cfg_ack,
   output logic             cfg_err
);

   logic [IDX_W-1:0] shadow_tbl [WIDTH];
   logic [IDX_W-1:0] active_tbl [WIDTH];
   logic [WIDTH-1:0] written;
   logic [WIDTH-1:0] perm_data;
   logic [WIDTH-1:0] next_data;
   logic             accept;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      perm_data = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         perm_data[i] = in_data[active_tbl[i]];
      end
      next_data = perm_en ? perm_data : in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= next_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // The commit copy uses the pre-edge shadow. A same-cycle write is ordered
   // after the copy and after the bitmap clear, so its entry and its bitmap
   // bit both survive into the next configuration round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            shadow_tbl[i] <= IDX_W'(i);
            active_tbl[i] <= IDX_W'(i);
         end
         written <= '0;
         cfg_ack <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         cfg_ack <= 1'b0;
         cfg_err <= 1'b0;
         if (cfg_commit) begin
            if (&written) begin
               active_tbl <= shadow_tbl;
               written    <= '0;
               cfg_ack    <= 1'b1;
            end else begin
               cfg_err <= 1'b1;
            end
         end
         if (cfg_we) begin
            shadow_tbl[cfg_addr] <= cfg_data;
            written[cfg_addr]    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_chaos_bit_permuter.sv
// tb_chaos_bit_permuter
//   Directed bench for chaos_bit_permuter with WIDTH=8. It uses table-driven
//   single-beat vectors and hand-written sequences for configuration, back-
//   pressure and reset corner cases.
module tb_chaos_bit_permuter;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         perm_en;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         cfg_we;
   logic [2:0]   cfg_addr;
   logic [2:0]   cfg_data;
   logic         cfg_commit;
   logic         cfg_ack;
   logic         cfg_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] din;
      logic       pen;
      logic [7:0] exp;
   } vec_t;

   vec_t rev_vecs [6];

   chaos_bit_permuter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .perm_en    (perm_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_commit (cfg_commit),
      .cfg_ack    (cfg_ack),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, and outputs are sampled at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [2:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic write_reversal();
      for (int i = 0; i < 8; i++) cfg_write(3'(i), 3'(7 - i));
   endtask

   task automatic write_identity();
      for (int i = 0; i < 8; i++) cfg_write(3'(i), 3'(i));
   endtask

   task automatic commit_expect(input string name, input logic exp_ack);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      check1({name, "_ack"}, cfg_ack, exp_ack);
      check1({name, "_err"}, cfg_err, !exp_ack);
      tick();
      check1({name, "_pulse_end"}, cfg_ack | cfg_err, 1'b0);
   endtask

   task automatic beat_expect(input string name, input logic [7:0] d, input logic pen,
                              input logic [7:0] exp);
      in_valid = 1'b1;
      in_data  = d;
      perm_en  = pen;
      tick();
      in_valid = 1'b0;
      check1({name, "_valid"}, out_valid, 1'b1);
      check8({name, "_data"}, out_data, exp);
   endtask

   initial begin
      rev_vecs[0] = '{din: 8'h01, pen: 1'b1, exp: 8'h80};
      rev_vecs[1] = '{din: 8'h01, pen: 1'b0, exp: 8'h01};
      rev_vecs[2] = '{din: 8'h0F, pen: 1'b1, exp: 8'hF0};
      rev_vecs[3] = '{din: 8'hC5, pen: 1'b1, exp: 8'hA3};
      rev_vecs[4] = '{din: 8'h36, pen: 1'b1, exp: 8'h6C};
      rev_vecs[5] = '{din: 8'hC5, pen: 1'b0, exp: 8'hC5};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; perm_en = 1'b0;
      out_ready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      cfg_commit = 1'b0;
      #12;
      check1("rst_out_valid", out_valid, 1'b0);
      check8("rst_out_data", out_data, 8'h00);
      check1("rst_cfg_ack", cfg_ack, 1'b0);
      check1("rst_cfg_err", cfg_err, 1'b0);
      check1("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;

      // Identity table after reset
      beat_expect("ident_a5", 8'hA5, 1'b1, 8'hA5);
      beat_expect("ident_3c", 8'h3C, 1'b1, 8'h3C);

      // Program the reversal table and run vectors back-to-back
      write_reversal();
      commit_expect("rev_commit", 1'b1);
      for (int i = 0; i < 6; i++) begin
         beat_expect($sformatf("rev_vec%0d", i), rev_vecs[i].din, rev_vecs[i].pen, rev_vecs[i].exp);
      end
      tick();
      check1("drain_valid", out_valid, 1'b0);

      // Partial rewrite: commit rejected, old table kept
      for (int i = 0; i < 5; i++) cfg_write(3'(i), 3'(i));
      commit_expect("partial_commit", 1'b0);
      beat_expect("partial_keep", 8'h01, 1'b1, 8'h80);

      // Commit held two cycles: first accepted, second rejected
      write_identity();
      cfg_commit = 1'b1;
      tick();
      check1("hold1_ack", cfg_ack, 1'b1);
      tick();
      cfg_commit = 1'b0;
      check1("hold2_ack", cfg_ack, 1'b0);
      check1("hold2_err", cfg_err, 1'b1);
      tick();

      // Commit and beat in the same cycle: the beat sees the old identity table
      write_reversal();
      cfg_commit = 1'b1;
      in_valid = 1'b1; in_data = 8'h01; perm_en = 1'b1;
      tick();
      cfg_commit = 1'b0;
      check1("same_cyc_ack", cfg_ack, 1'b1);
      check8("same_cyc_old_tbl", out_data, 8'h01);
      tick();
      in_valid = 1'b0;
      check8("same_cyc_new_tbl", out_data, 8'h80);

      // Write and commit in the same cycle: the pre-edge shadow is copied, and the write survives
      write_identity();
      cfg_commit = 1'b1;
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 3'd3;
      tick();
      cfg_commit = 1'b0; cfg_we = 1'b0;
      check1("wc_ack", cfg_ack, 1'b1);
      beat_expect("wc_copy_pre", 8'h01, 1'b1, 8'h01);
      commit_expect("wc_bitmap_partial", 1'b0);

      // Backpressure: 11, 22, 33 with out_ready low for two cycles
      in_valid = 1'b1; in_data = 8'h11; perm_en = 1'b1; out_ready = 1'b1;
      tick();
      check8("bp_first", out_data, 8'h11);
      out_ready = 1'b0; in_data = 8'h22;
      #1;
      check1("bp_in_ready_low", in_ready, 1'b0);
      tick();
      check8("bp_hold1", out_data, 8'h11);
      tick();
      check8("bp_hold2", out_data, 8'h11);
      check1("bp_hold_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      tick();
      check8("bp_second", out_data, 8'h22);
      in_data = 8'h33;
      tick();
      check8("bp_third", out_data, 8'h33);
      in_valid = 1'b0;
      tick();
      check1("bp_drain", out_valid, 1'b0);

      // Asynchronous reset mid-stream
      write_reversal();
      commit_expect("pre_rst_commit", 1'b1);
      write_reversal();
      out_ready = 1'b0;
      beat_expect("pre_rst_beat", 8'h01, 1'b1, 8'h80);
      #2;
      rst_n = 1'b0;
      #1;
      check1("async_rst_valid", out_valid, 1'b0);
      check8("async_rst_data", out_data, 8'h00);
      #3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      commit_expect("post_rst_bitmap", 1'b0);
      beat_expect("post_rst_ident", 8'h01, 1'b1, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
